// File: rtl/vec_mem_seq_if.sv
// Bus bundle between the execute stage / DRAM port and the vector memory
// sequencer. The master side is the environment (execute stage plus DRAM),
// the slave side is the sequencer itself.
interface vec_mem_seq_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int IW = 4
);
    // Execute-stage command and store data
    logic          Start;
    logic          IsWrite;
    logic [AW-1:0] Base;
    logic [AW-1:0] Stride;
    logic [4:0]    Len;
    logic [DW-1:0] WrData;
    logic          WrReq;

    // Load element stream and status
    logic [DW-1:0] RdData;
    logic          RdValid;
    logic [IW-1:0] RdIdx;
    logic          Busy;
    logic          Done;

    // DRAM pins
    logic [AW-1:0] Addr;
    logic          RD;
    logic          WR;
    logic [DW-1:0] MemDataOut;
    logic [DW-1:0] MemDataIn;

    modport master (
        output Start, IsWrite, Base, Stride, Len, WrData, MemDataIn,
        input  WrReq, RdData, RdValid, RdIdx, Busy, Done,
               Addr, RD, WR, MemDataOut
    );

    modport slave (
        input  Start, IsWrite, Base, Stride, Len, WrData, MemDataIn,
        output WrReq, RdData, RdValid, RdIdx, Busy, Done,
               Addr, RD, WR, MemDataOut
    );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer. On Start it issues Len single-word DRAM
// accesses at Base, Base+Stride, ... (one per cycle). Loads return an indexed,
// registered element stream; stores consume one element per cycle.
module vec_mem_seq #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_LEN = 16,
    parameter int RD_LAT  = 1
) (
    input  logic           Clk1,
    input  logic           Reset,
    vec_mem_seq_if.slave   bus
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int CW = 5;
    localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);
    localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    state_e             state_q,     state_d;
    logic               is_write_q,  is_write_d;
    logic [AW-1:0]      stride_q,    stride_d;
    logic [AW-1:0]      next_addr_q, next_addr_d;
    logic [CW-1:0]      remain_q,    remain_d;
    logic [CW-1:0]      len_q,       len_d;
    logic [CW-1:0]      rcv_cnt_q,   rcv_cnt_d;
    logic               rd_q,        rd_d;
    logic               wr_q,        wr_d;
    logic [AW-1:0]      addr_q,      addr_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [RD_LAT-1:0]  pipe_q,      pipe_d;
    logic               rd_valid_q,  rd_valid_d;
    logic [DW-1:0]      rd_data_q,   rd_data_d;
    logic [IW-1:0]      rd_idx_q,    rd_idx_d;

    logic [CW-1:0]      len_eff_s;
    logic               capture_s;

    // Clamp the requested element count to the supported maximum
    always_comb begin
        if (bus.Len > MAX_LEN_C) begin
            len_eff_s = MAX_LEN_C;
        end else begin
            len_eff_s = bus.Len;
        end
    end

    // Sequencer FSM: command capture, address accumulation and strobe generation
    always_comb begin
        state_d     = state_q;
        is_write_d  = is_write_q;
        stride_d    = stride_q;
        len_d       = len_q;
        next_addr_d = next_addr_q;
        remain_d    = remain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        addr_d      = {AW{1'b0}};
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.Start) begin
                    is_write_d = bus.IsWrite;
                    stride_d   = bus.Stride;
                    len_d      = len_eff_s;
                    busy_d     = 1'b1;
                    if (len_eff_s == ZERO_C) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        // First access goes out in the very next cycle
                        state_d     = ST_ISSUE;
                        rd_d        = ~bus.IsWrite;
                        wr_d        = bus.IsWrite;
                        addr_d      = bus.Base;
                        next_addr_d = bus.Base + bus.Stride;
                        remain_d    = len_eff_s - ONE_C;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // remain_q counts accesses still to issue after the one on the pins now
                if (remain_q != ZERO_C) begin
                    state_d     = ST_ISSUE;
                    rd_d        = ~is_write_q;
                    wr_d        = is_write_q;
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + stride_q;
                    remain_d    = remain_q - ONE_C;
                end else if (is_write_q) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Element counter and valid flag update together on the last capture
                if (rd_valid_q && (rcv_cnt_q == len_q)) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Read return path: track in-flight reads and register returning elements
    always_comb begin
        pipe_d    = {RD_LAT{1'b0}};
        pipe_d[0] = rd_q;
        for (int j = 1; j < RD_LAT; j++) begin
            pipe_d[j] = pipe_q[j-1];
        end
        capture_s  = pipe_q[RD_LAT-1];
        rd_valid_d = capture_s;
        if (capture_s) begin
            rd_data_d = bus.MemDataIn;
            rd_idx_d  = rcv_cnt_q[IW-1:0];
        end else begin
            rd_data_d = rd_data_q;
            rd_idx_d  = rd_idx_q;
        end
        if (state_q == ST_IDLE) begin
            rcv_cnt_d = ZERO_C;
        end else if (capture_s) begin
            rcv_cnt_d = rcv_cnt_q + ONE_C;
        end else begin
            rcv_cnt_d = rcv_cnt_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            is_write_q  <= 1'b0;
            stride_q    <= {AW{1'b0}};
            next_addr_q <= {AW{1'b0}};
            remain_q    <= ZERO_C;
            len_q       <= ZERO_C;
            rcv_cnt_q   <= ZERO_C;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= {AW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pipe_q      <= {RD_LAT{1'b0}};
            rd_valid_q  <= 1'b0;
            rd_data_q   <= {DW{1'b0}};
            rd_idx_q    <= {IW{1'b0}};
        end else begin
            state_q     <= state_d;
            is_write_q  <= is_write_d;
            stride_q    <= stride_d;
            next_addr_q <= next_addr_d;
            remain_q    <= remain_d;
            len_q       <= len_d;
            rcv_cnt_q   <= rcv_cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pipe_q      <= pipe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_idx_q    <= rd_idx_d;
        end
    end

    // Store data is a combinational pass, gated so the pins are quiet otherwise
    assign bus.MemDataOut = wr_q ? bus.WrData : {DW{1'b0}};
    assign bus.WrReq      = wr_q;
    assign bus.RD         = rd_q;
    assign bus.WR         = wr_q;
    assign bus.Addr       = addr_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.RdValid    = rd_valid_q;
    assign bus.RdData     = rd_data_q;
    assign bus.RdIdx      = rd_idx_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed self-checking bench for vec_mem_seq with a behavioural DRAM
// (RD_LAT = 1). Every cycle of each operation is compared against a packed
// vector of all outputs built from hand-derived cycle timing.
module tb_vec_mem_seq;
    localparam int RD_LAT = 1;

    logic Clk1 = 1'b0;
    logic Reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] exp_rdd;

    vec_mem_seq_if #(.AW(16), .DW(16), .IW(4)) bus ();

    vec_mem_seq #(.AW(16), .DW(16), .MAX_LEN(16), .RD_LAT(RD_LAT)) dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk1 = ~Clk1;

    // DRAM model: unwritten words hold a fixed pattern, 0x10..0x13 hold A0..A3
    logic [15:0] mem    [0:65535];
    bit          mem_wr [0:65535];
    logic [15:0] rd_ret = 16'h0000;

    function automatic logic [15:0] dram_rd(input logic [15:0] a);
        if (mem_wr[a]) return mem[a];
        else if (a >= 16'h0010 && a <= 16'h0013) return 16'h00A0 + (a - 16'h0010);
        else return a ^ 16'hC3C3;
    endfunction

    always @(posedge Clk1) begin
        if (bus.RD) rd_ret <= dram_rd(bus.Addr);
        if (bus.WR) begin
            mem[bus.Addr]    <= bus.MemDataOut;
            mem_wr[bus.Addr] <= 1'b1;
        end
    end
    assign bus.MemDataIn = rd_ret;

    function automatic logic [63:0] pack(input logic busy, done, rd, wr, wrreq, rdv,
                                         input logic [3:0] idx,
                                         input logic [15:0] addr, rdd, mdo);
        return {6'd0, busy, done, rd, wr, wrreq, rdv, (rdv ? idx : 4'd0), addr, rdd, mdo};
    endfunction

    function automatic logic [63:0] obs_now();
        return pack(bus.Busy, bus.Done, bus.RD, bus.WR, bus.WrReq, bus.RdValid,
                    bus.RdIdx, bus.Addr, bus.RdData, bus.MemDataOut);
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge Clk1);
        #1;
    endtask

    // One load operation, checked cycle by cycle from cycle 0 to one idle cycle after Done
    task automatic run_load(input string tag, input logic [15:0] base, stride,
                            input logic [4:0] len_in, input int exp_len, input bit poke);
        int done_c;
        logic rd, v;
        logic [15:0] a;
        int i;
        tick();
        bus.Start = 1'b1; bus.IsWrite = 1'b0; bus.Base = base; bus.Stride = stride; bus.Len = len_in;
        #1;
        chk($sformatf("%s_c0", tag), obs_now(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, exp_rdd, 16'h0000));
        done_c = (exp_len == 0) ? 1 : exp_len + RD_LAT + 2;
        for (int c = 1; c <= done_c; c++) begin
            tick();
            if (poke && c >= 2 && c <= 5) begin
                bus.Start = 1'b1; bus.IsWrite = 1'b1; bus.Base = 16'h7777; bus.Len = 5'd2;
            end else begin
                bus.Start = 1'b0;
            end
            #1;
            rd = (c <= exp_len);
            a  = base + stride * 16'(c - 1);
            i  = c - RD_LAT - 2;
            v  = (exp_len != 0) && (c >= RD_LAT + 2) && (c <= exp_len + RD_LAT + 1);
            if (v) exp_rdd = dram_rd(base + stride * 16'(i));
            chk($sformatf("%s_c%0d", tag, c), obs_now(),
                pack(1'b1, (c == done_c), rd, 1'b0, 1'b0, v, 4'(i), (rd ? a : 16'h0000), exp_rdd, 16'h0000));
        end
        tick();
        bus.Start = 1'b0;
        #1;
        chk($sformatf("%s_idle", tag), obs_now(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, exp_rdd, 16'h0000));
    endtask

    initial begin
        logic [15:0] wd [3];
        logic [15:0] sa;
        wd[0] = 16'h0011; wd[1] = 16'h0022; wd[2] = 16'h0033;

        // 1: reset held two cycles, junk on WrData must not reach the pins
        Reset = 1'b1; bus.Start = 1'b0; bus.IsWrite = 1'b0; bus.Base = 16'h0000;
        bus.Stride = 16'h0000; bus.Len = 5'd0; bus.WrData = 16'hBEEF;
        tick(); tick();
        exp_rdd = 16'h0000;
        chk("reset", obs_now(), 64'h0);
        Reset = 1'b0; bus.WrData = 16'h0000;

        // 2: unit-stride load of A0..A3
        run_load("ld_unit", 16'h0010, 16'h0001, 5'd4, 4, 1'b0);
        // 4: negative stride, then zero-length
        run_load("ld_neg", 16'h0008, 16'hFFFE, 5'd3, 3, 1'b0);
        run_load("len0", 16'h1234, 16'h0001, 5'd0, 0, 1'b0);
        // 5: Start pulsed while busy, Len=31 clamps to 16
        run_load("len31", 16'h0200, 16'h0001, 5'd31, 16, 1'b1);

        // 6: reset in cycle 2 of a Len=8 load
        tick();
        bus.Start = 1'b1; bus.IsWrite = 1'b0; bus.Base = 16'h0040; bus.Stride = 16'h0003; bus.Len = 5'd8;
        #1;
        chk("rst_c0", obs_now(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, exp_rdd, 16'h0000));
        tick(); bus.Start = 1'b0; #1;
        chk("rst_c1", obs_now(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0040, exp_rdd, 16'h0000));
        tick(); Reset = 1'b1; #1;
        chk("rst_c2", obs_now(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0043, exp_rdd, 16'h0000));
        tick(); Reset = 1'b0; #1;
        exp_rdd = 16'h0000;
        chk("rst_c3", obs_now(), 64'h0);
        for (int c = 4; c <= 14; c++) begin
            tick(); #1;
            chk($sformatf("rst_quiet_c%0d", c), obs_now(), 64'h0);
        end
        run_load("rst_fresh", 16'h0100, 16'h0001, 5'd2, 2, 1'b0);

        // 3: store with address wrap
        tick();
        bus.Start = 1'b1; bus.IsWrite = 1'b1; bus.Base = 16'hFFFE; bus.Stride = 16'h0001; bus.Len = 5'd3;
        bus.WrData = 16'h0000;
        #1;
        chk("st_c0", obs_now(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, exp_rdd, 16'h0000));
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.Start = 1'b0; bus.IsWrite = 1'b0;
            bus.WrData = wd[c-1];
            #1;
            sa = 16'hFFFE + 16'(c - 1);
            chk($sformatf("st_c%0d", c), obs_now(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, sa, exp_rdd, wd[c-1]));
        end
        tick(); bus.WrData = 16'h0000; #1;
        chk("st_c4_done", obs_now(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, exp_rdd, 16'h0000));
        tick(); #1;
        chk("st_idle", obs_now(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, exp_rdd, 16'h0000));
        chk("dump_fffe", {48'h0, dram_rd(16'hFFFE)}, 64'h0011);
        chk("dump_ffff", {48'h0, dram_rd(16'hFFFF)}, 64'h0022);
        chk("dump_0000", {48'h0, dram_rd(16'h0000)}, 64'h0033);
        chk("dump_fffd", {48'h0, dram_rd(16'hFFFD)}, {48'h0, 16'hFFFD ^ 16'hC3C3});
        chk("dump_0001", {48'h0, dram_rd(16'h0001)}, {48'h0, 16'h0001 ^ 16'hC3C3});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
